// File: rtl/fpu_conv_s2d_seq.sv
// Sequential binary32 -> binary64 widening converter with valid/ready on both sides.
// Define FPU_S2D_DENORM_EN to normalise denormal inputs; otherwise they flush to signed zero.
module fpu_conv_s2d_seq #(
    parameter bit CANON_NAN = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] inVal,
    output logic        outValid,
    input  logic        outReady,
    output logic [63:0] outVal,
    output logic        outDenorm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT stateReg;
    stateT stateNext;

    logic [63:0] outValReg;
    logic        outDenormReg;

    logic        inSign;
    logic [7:0]  inExp;
    logic [22:0] inMan;
    logic        expIsZero;
    logic        expIsMax;
    logic        manIsZero;
    logic        isDenormIn;
    logic        accept;
    logic [63:0] fastResult;

    assign inSign     = inVal[31];
    assign inExp      = inVal[30:23];
    assign inMan      = inVal[22:0];
    assign expIsZero  = (inExp == 8'd0);
    assign expIsMax   = (inExp == 8'hFF);
    assign manIsZero  = (inMan == 23'd0);
    assign isDenormIn = expIsZero && !manIsZero;
    assign accept     = inValid && (stateReg == IDLE);

    // Single-cycle result for everything except normalised denormals.
    // Zero-exponent inputs land on signed zero here, which is also the flush value.
    always_comb begin
        fastResult = {inSign, 63'd0};
        if (expIsMax) begin
            if (manIsZero) begin
                fastResult = {inSign, 11'h7FF, 52'd0};
            end else if (CANON_NAN) begin
                fastResult = {inSign, 63'h7FF8000000000000};
            end else begin
                fastResult = {inSign, 11'h7FF, inMan, 29'd0};
            end
        end else if (!expIsZero) begin
            fastResult = {inSign, {3'd0, inExp} + 11'd896, inMan, 29'd0};
        end
    end

`ifdef FPU_S2D_DENORM_EN
    logic [23:0] shifterReg;
    logic [4:0]  countReg;
    logic        signReg;
    logic [23:0] shifterNext;
    logic [4:0]  countNext;
    logic        normDone;

    assign shifterNext = {shifterReg[22:0], 1'b0};
    assign countNext   = countReg + 5'd1;
    assign normDone    = shifterNext[23];
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (inValid) begin
`ifdef FPU_S2D_DENORM_EN
                    stateNext = isDenormIn ? NORM : DONE;
`else
                    stateNext = DONE;
`endif
                end
            end
`ifdef FPU_S2D_DENORM_EN
            NORM: begin
                if (normDone) begin
                    stateNext = DONE;
                end
            end
`endif
            DONE: begin
                if (outReady) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        inReady   = (stateReg == IDLE);
        outValid  = (stateReg == DONE);
        outVal    = outValReg;
        outDenorm = outDenormReg;
    end

    // Result registers only change on a single-cycle accept or when normalisation finishes,
    // so the result stays bit-identical through DONE and keeps its old value in IDLE/NORM.
    always_ff @(posedge clock) begin
        if (reset) begin
            outValReg    <= 64'd0;
            outDenormReg <= 1'b0;
        end else begin
`ifdef FPU_S2D_DENORM_EN
            if (accept && !isDenormIn) begin
                outValReg    <= fastResult;
                outDenormReg <= 1'b0;
            end else if (stateReg == NORM && normDone) begin
                outValReg    <= {signReg, 11'd897 - {6'd0, countNext}, shifterNext[22:0], 29'd0};
                outDenormReg <= 1'b1;
            end
`else
            if (accept) begin
                outValReg    <= fastResult;
                outDenormReg <= isDenormIn;
            end
`endif
        end
    end

`ifdef FPU_S2D_DENORM_EN
    // Shift until the leading one reaches bit 23; k counts the shifts taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            shifterReg <= 24'd0;
            countReg   <= 5'd0;
            signReg    <= 1'b0;
        end else if (accept && isDenormIn) begin
            shifterReg <= {1'b0, inMan};
            countReg   <= 5'd0;
            signReg    <= inSign;
        end else if (stateReg == NORM) begin
            shifterReg <= shifterNext;
            countReg   <= countNext;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_conv_s2d_seq.sv
// Directed bench for fpu_conv_s2d_seq: conversions, latency, backpressure and reset recovery.
// A second instance with CANON_NAN=1 shares the inputs to check canonical NaN output.
module tb_fpu_conv_s2d_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [31:0] inVal;
    logic        outValid;
    logic        outReady;
    logic [63:0] outVal;
    logic        outDenorm;

    logic        inReadyC;
    logic        outValidC;
    logic [63:0] outValC;
    logic        outDenormC;

    int errors = 0;
    int checks = 0;
    int lat;

    always #5 clock = ~clock;

    fpu_conv_s2d_seq #(.CANON_NAN(1'b0)) dut (
        .clock    (clock),
        .reset    (reset),
        .inValid  (inValid),
        .inReady  (inReady),
        .inVal    (inVal),
        .outValid (outValid),
        .outReady (outReady),
        .outVal   (outVal),
        .outDenorm(outDenorm)
    );

    fpu_conv_s2d_seq #(.CANON_NAN(1'b1)) dutCanon (
        .clock    (clock),
        .reset    (reset),
        .inValid  (inValid),
        .inReady  (inReadyC),
        .inVal    (inVal),
        .outValid (outValidC),
        .outReady (outReady),
        .outVal   (outValC),
        .outDenorm(outDenormC)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents one operand, measures cycles from the accept edge to outValid, leaves result held.
    task automatic convert(input logic [31:0] v, output int latency);
        chk("inReady_before_accept", {63'd0, inReady}, 64'd1);
        inValid = 1'b1;
        inVal   = v;
        @(posedge clock); #1;
        inValid = 1'b0;
        inVal   = 32'hDEADBEEF;
        latency = 1;
        while (outValid !== 1'b1 && latency < 40) begin
            @(posedge clock); #1;
            latency++;
        end
    endtask

    task automatic release_result();
        outReady = 1'b1;
        @(posedge clock); #1;
        outReady = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] v, input logic [63:0] expVal,
                       input logic expDen, input int expLat);
        convert(v, lat);
        $display("xfer %s in=%h out=%h denorm=%0b lat=%0d", tag, v, outVal, outDenorm, lat);
        chk({tag, "_val"}, outVal, expVal);
        chk({tag, "_denorm"}, {63'd0, outDenorm}, {63'd0, expDen});
        chk({tag, "_lat"}, 64'(lat), 64'(expLat));
        release_result();
    endtask

    initial begin
        reset    = 1'b1;
        inValid  = 1'b0;
        inVal    = 32'd0;
        outReady = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        chk("rst_outVal", outVal, 64'd0);
        chk("rst_outDenorm", {63'd0, outDenorm}, 64'd0);
        chk("rst_inReady", {63'd0, inReady}, 64'd1);
        chk("rst_outValid", {63'd0, outValid}, 64'd0);

        run("one",    32'h3F800000, 64'h3FF0000000000000, 1'b0, 1);
        run("negtwo", 32'hC0000000, 64'hC000000000000000, 1'b0, 1);
        run("inf",    32'h7F800000, 64'h7FF0000000000000, 1'b0, 1);
        run("negzero",32'h80000000, 64'h8000000000000000, 1'b0, 1);
        run("maxnorm",32'h7F7FFFFF, 64'h47EFFFFFE0000000, 1'b0, 1);
        run("minnorm",32'h00800000, 64'h3810000000000000, 1'b0, 1);
        run("snan",   32'h7F800001, 64'h7FF0000020000000, 1'b0, 1);

        convert(32'h7FC00001, lat);
        $display("xfer qnan in=7fc00001 out=%h canon=%h lat=%0d", outVal, outValC, lat);
        chk("qnan_copy", outVal, 64'h7FF8000020000000);
        chk("qnan_canon", outValC, 64'h7FF8000000000000);
        chk("qnan_lat", 64'(lat), 64'd1);
        release_result();

`ifdef FPU_S2D_DENORM_EN
        run("den_half", 32'h00400000, 64'h3800000000000000, 1'b1, 2);
        run("den_min",  32'h00000001, 64'h36A0000000000000, 1'b1, 24);
        run("den_neg3", 32'h80000003, 64'hB6B8000000000000, 1'b1, 23);
`else
        run("den_min",  32'h00000001, 64'h0000000000000000, 1'b1, 1);
        run("den_neg3", 32'h80000003, 64'h8000000000000000, 1'b1, 1);
`endif
        run("after_den", 32'h3F800000, 64'h3FF0000000000000, 1'b0, 1);

        // Backpressure: result held, second operand ignored until released
        convert(32'h3F800000, lat);
        chk("bp_first", outVal, 64'h3FF0000000000000);
        inValid = 1'b1;
        inVal   = 32'h40000000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            $display("xfer bp_hold cycle=%0d out=%h inReady=%0b outValid=%0b", i, outVal, inReady, outValid);
            chk("bp_hold_val", outVal, 64'h3FF0000000000000);
            chk("bp_hold_inReady", {63'd0, inReady}, 64'd0);
            chk("bp_hold_outValid", {63'd0, outValid}, 64'd1);
        end
        outReady = 1'b1;
        @(posedge clock); #1;
        outReady = 1'b0;
        chk("bp_rel_inReady", {63'd0, inReady}, 64'd1);
        chk("bp_rel_outValid", {63'd0, outValid}, 64'd0);
        @(posedge clock); #1;
        inValid = 1'b0;
        $display("xfer bp_second out=%h outValid=%0b", outVal, outValid);
        chk("bp_second_valid", {63'd0, outValid}, 64'd1);
        chk("bp_second_val", outVal, 64'h4000000000000000);
        release_result();

        // Reset in the middle of an operation
        inValid = 1'b1;
        inVal   = 32'h00000001;
        @(posedge clock); #1;
        inValid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
`ifndef FPU_S2D_DENORM_EN
        chk("pre_rst_denorm", {63'd0, outDenorm}, 64'd1);
`endif
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        $display("xfer midrst out=%h outValid=%0b inReady=%0b", outVal, outValid, inReady);
        chk("midrst_outValid", {63'd0, outValid}, 64'd0);
        chk("midrst_outVal", outVal, 64'd0);
        chk("midrst_inReady", {63'd0, inReady}, 64'd1);
        chk("midrst_outDenorm", {63'd0, outDenorm}, 64'd0);
        run("post_rst", 32'h3F800000, 64'h3FF0000000000000, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
